// File: rtl/rom_arbiter.sv
`default_nettype none
// rom_arbiter: three-port ROM read arbiter sharing one SDRAM read channel.
// Define ROM_ARB_RR_EN for round-robin arbitration; default is fixed priority 0>1>2.
module rom_arbiter #(
   parameter int ADDR_W = 23,
   parameter int DATA_W = 16,
   parameter int TMO    = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              req2,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [ADDR_W-1:0] addr2,
   output logic              valid0,
   output logic              valid1,
   output logic              valid2,
   output logic [DATA_W-1:0] dout,
   output logic              sdram_req,
   output logic [ADDR_W-1:0] sdram_addr,
   input  logic [DATA_W-1:0] sdram_data,
   input  logic              sdram_valid,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   // Last WAIT cycle index: WAIT lasts exactly TMO cycles before a retry.
   localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

   state_t              state, state_next;
   logic [1:0]          grant, grant_next;
   logic                sdram_req_next;
   logic [ADDR_W-1:0]   sdram_addr_next;
   logic [DATA_W-1:0]   dout_next;
   logic [2:0]          valid, valid_next;
   logic [7:0]          timer, timer_next;
   logic [2:0]          req_vec;
   logic [1:0]          arb_idx;
   logic [ADDR_W-1:0]   arb_addr;

   assign req_vec = {req2, req1, req0};
   assign valid0  = valid[0];
   assign valid1  = valid[1];
   assign valid2  = valid[2];
   assign busy    = (state != S_IDLE);

`ifdef ROM_ARB_RR_EN
   logic [1:0] rr_ptr, rr_ptr_next;
   logic [2:0] rr_sum;
   logic [1:0] rr_cand;

   // Scan from lowest to highest priority so the port nearest rr_ptr wins.
   always_comb begin
      arb_idx = 2'd0;
      rr_sum  = 3'd0;
      rr_cand = 2'd0;
      for (int i = 2; i >= 0; i--) begin
         rr_sum  = {1'b0, rr_ptr} + 3'(i);
         rr_cand = (rr_sum >= 3'd3) ? 2'(rr_sum - 3'd3) : rr_sum[1:0];
         if (req_vec[rr_cand]) arb_idx = rr_cand;
      end
   end
`else
   always_comb begin
      if (req0)      arb_idx = 2'd0;
      else if (req1) arb_idx = 2'd1;
      else           arb_idx = 2'd2;
   end
`endif

   always_comb begin
      case (arb_idx)
         2'd0:    arb_addr = addr0;
         2'd1:    arb_addr = addr1;
         default: arb_addr = addr2;
      endcase
   end

   always_comb begin
      state_next      = state;
      grant_next      = grant;
      sdram_req_next  = sdram_req;
      sdram_addr_next = sdram_addr;
      dout_next       = dout;
      valid_next      = 3'b000;
      timer_next      = timer;
`ifdef ROM_ARB_RR_EN
      rr_ptr_next     = rr_ptr;
`endif
      case (state)
         S_IDLE: begin
            if (|req_vec) begin
               grant_next      = arb_idx;
               sdram_addr_next = arb_addr;
               sdram_req_next  = 1'b1;
               timer_next      = 8'd0;
               state_next      = S_WAIT;
`ifdef ROM_ARB_RR_EN
               rr_ptr_next     = (arb_idx == 2'd2) ? 2'd0 : arb_idx + 2'd1;
`endif
            end
         end
         S_WAIT: begin
            // Data always lands in dout; the pulse only goes out if the requester still waits.
            if (sdram_valid) begin
               dout_next         = sdram_data;
               sdram_req_next    = 1'b0;
               valid_next[grant] = req_vec[grant];
               state_next        = S_DONE;
            end else if (timer == TMO_LAST) begin
               // The IDLE cycle that follows is the single low cycle before the retry.
               sdram_req_next = 1'b0;
               timer_next     = 8'd0;
               state_next     = S_IDLE;
            end else begin
               timer_next = timer + 8'd1;
            end
         end
         S_DONE:  state_next = S_GAP;
         S_GAP:   state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         grant      <= 2'd0;
         sdram_req  <= 1'b0;
         sdram_addr <= '0;
         dout       <= '0;
         valid      <= 3'b000;
         timer      <= 8'd0;
`ifdef ROM_ARB_RR_EN
         rr_ptr     <= 2'd0;
`endif
      end else begin
         state      <= state_next;
         grant      <= grant_next;
         sdram_req  <= sdram_req_next;
         sdram_addr <= sdram_addr_next;
         dout       <= dout_next;
         valid      <= valid_next;
         timer      <= timer_next;
`ifdef ROM_ARB_RR_EN
         rr_ptr     <= rr_ptr_next;
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rom_arbiter.sv
`default_nettype none
// Directed self-checking bench for rom_arbiter, built with TMO = 4.
module tb_rom_arbiter;

   localparam int ADDR_W = 23;
   localparam int DATA_W = 16;
   localparam int TMO    = 4;

`ifdef ROM_ARB_RR_EN
   localparam int N_GRANTS  = 4;
   localparam int ORDER [4] = '{0, 1, 2, 0};
   localparam bit HOLD0     = 1'b1;
   localparam int EXP_V0    = 5;
`else
   localparam int N_GRANTS  = 3;
   localparam int ORDER [3] = '{0, 1, 2};
   localparam bit HOLD0     = 1'b0;
   localparam int EXP_V0    = 4;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              req0, req1, req2;
   logic [ADDR_W-1:0] addr0, addr1, addr2;
   logic              valid0, valid1, valid2;
   logic [DATA_W-1:0] dout;
   logic              sdram_req;
   logic [ADDR_W-1:0] sdram_addr;
   logic [DATA_W-1:0] sdram_data;
   logic              sdram_valid;
   logic              busy;

   int n_cmp  = 0;
   int n_fail = 0;
   int cnt_v0 = 0, cnt_v1 = 0, cnt_v2 = 0, cnt_multi = 0;

   always #5 clk = ~clk;

   rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TMO(TMO)) dut (
      .clk        (clk),
      .reset      (reset),
      .req0       (req0),
      .req1       (req1),
      .req2       (req2),
      .addr0      (addr0),
      .addr1      (addr1),
      .addr2      (addr2),
      .valid0     (valid0),
      .valid1     (valid1),
      .valid2     (valid2),
      .dout       (dout),
      .sdram_req  (sdram_req),
      .sdram_addr (sdram_addr),
      .sdram_data (sdram_data),
      .sdram_valid(sdram_valid),
      .busy       (busy)
   );

   always @(negedge clk) begin
      if (valid0) cnt_v0++;
      if (valid1) cnt_v1++;
      if (valid2) cnt_v2++;
      if ((int'(valid0) + int'(valid1) + int'(valid2)) > 1) cnt_multi++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_req(input string tag);
      int n;
      n = 0;
      while (sdram_req !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk(tag, 32'(sdram_req), 32'd1);
   endtask

   task automatic respond(input string tag, input logic [DATA_W-1:0] data,
                          input int delay, input logic [2:0] exp_valid);
      repeat (delay) tick();
      sdram_valid = 1'b1;
      sdram_data  = data;
      tick();
      sdram_valid = 1'b0;
      chk({tag, "_valid"}, 32'({valid2, valid1, valid0}), 32'(exp_valid));
      chk({tag, "_dout"}, 32'(dout), 32'(data));
      chk({tag, "_sreq"}, 32'(sdram_req), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;
      addr0 = '0; addr1 = '0; addr2 = '0;
      sdram_data = '0; sdram_valid = 1'b0;
      tick();
      tick();
      chk("rst_sreq", 32'(sdram_req), 32'd0);
      chk("rst_saddr", 32'(sdram_addr), 32'd0);
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_valid", 32'({valid2, valid1, valid0}), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      tick();
      chk("idle_busy", 32'(busy), 32'd0);

      // Single request on port 0, data two cycles after sdram_req.
      addr0 = 23'h000123;
      req0  = 1'b1;
      tick();
      chk("t1_sreq", 32'(sdram_req), 32'd1);
      chk("t1_saddr", 32'(sdram_addr), 32'h000123);
      chk("t1_busy", 32'(busy), 32'd1);
      respond("t1", 16'hBEEF, 2, 3'b001);
      req0 = 1'b0;
      tick();
      chk("t1_gap_valid", 32'({valid2, valid1, valid0}), 32'd0);
      chk("t1_gap_busy", 32'(busy), 32'd1);
      tick();
      chk("t1_idle_busy", 32'(busy), 32'd0);

      // Port 1 aborts after grant; address change must not leak through.
      addr1 = 23'h0ABCDE;
      req1  = 1'b1;
      tick();
      chk("t2_saddr", 32'(sdram_addr), 32'h0ABCDE);
      addr1 = 23'h011111;
      tick();
      chk("t2_addr_hold", 32'(sdram_addr), 32'h0ABCDE);
      req1 = 1'b0;
      tick();
      chk("t2_sreq", 32'(sdram_req), 32'd1);
      respond("t2", 16'h5A5A, 0, 3'b000);
      tick();
      chk("t2_gap_busy", 32'(busy), 32'd1);
      tick();
      chk("t2_idle_busy", 32'(busy), 32'd0);

      // All three requesters together from a fresh reset.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      addr0 = 23'h000100; addr1 = 23'h000200; addr2 = 23'h000300;
      req0 = 1'b1; req1 = 1'b1; req2 = 1'b1;
      for (int k = 0; k < N_GRANTS; k++) begin
         wait_req("t3_req");
         chk("t3_order", 32'(sdram_addr), 32'h100 * 32'(ORDER[k] + 1));
         respond("t3", 16'(16'hA000 + k), 1, 3'(1 << ORDER[k]));
         if (!HOLD0 || ORDER[k] != 0 || k == N_GRANTS - 1) begin
            case (ORDER[k])
               0:       req0 = 1'b0;
               1:       req1 = 1'b0;
               default: req2 = 1'b0;
            endcase
         end
         tick();
         chk("t3_gap_sreq", 32'(sdram_req), 32'd0);
      end
      tick();
      chk("t3_idle_busy", 32'(busy), 32'd0);

      // Data on the last WAIT cycle beats the timeout; held req re-arms.
      addr0 = 23'h000001;
      req0  = 1'b1;
      wait_req("t4_req");
      respond("t4", 16'h1234, 3, 3'b001);
      tick();
      chk("t4_gap_sreq", 32'(sdram_req), 32'd0);
      tick();
      chk("t4_idle_sreq", 32'(sdram_req), 32'd0);
      tick();
      chk("t4_rereq", 32'(sdram_req), 32'd1);
      chk("t4_rereq_addr", 32'(sdram_addr), 32'h000001);
      respond("t4b", 16'h4321, 0, 3'b001);
      req0 = 1'b0;
      tick();
      tick();
      chk("t4_idle_busy", 32'(busy), 32'd0);

      // Silent SDRAM: four WAIT cycles, one low cycle, then a retry.
      addr2 = 23'h7FFFFF;
      req2  = 1'b1;
      wait_req("t5_req");
      chk("t5_saddr", 32'(sdram_addr), 32'h7FFFFF);
      for (int i = 1; i < 4; i++) begin
         tick();
         chk("t5_hold", 32'(sdram_req), 32'd1);
      end
      tick();
      chk("t5_drop", 32'(sdram_req), 32'd0);
      tick();
      chk("t5_retry", 32'(sdram_req), 32'd1);
      chk("t5_retry_addr", 32'(sdram_addr), 32'h7FFFFF);
      respond("t5", 16'hC0DE, 0, 3'b100);
      req2 = 1'b0;
      tick();
      tick();
      chk("t5_idle_busy", 32'(busy), 32'd0);

      // Reset during WAIT, then a stray sdram_valid.
      addr0 = 23'h000456;
      req0  = 1'b1;
      wait_req("t6_req");
      tick();
      reset = 1'b1;
      tick();
      chk("t6_rst_sreq", 32'(sdram_req), 32'd0);
      chk("t6_rst_saddr", 32'(sdram_addr), 32'd0);
      chk("t6_rst_dout", 32'(dout), 32'd0);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      reset       = 1'b0;
      req0        = 1'b0;
      sdram_valid = 1'b1;
      sdram_data  = 16'hDEAD;
      tick();
      sdram_valid = 1'b0;
      chk("t6_valid", 32'({valid2, valid1, valid0}), 32'd0);
      chk("t6_dout", 32'(dout), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_sreq", 32'(sdram_req), 32'd0);
      tick();
      chk("t6_valid_late", 32'({valid2, valid1, valid0}), 32'd0);

      chk("cnt_valid0", 32'(cnt_v0), 32'(EXP_V0));
      chk("cnt_valid1", 32'(cnt_v1), 32'd1);
      chk("cnt_valid2", 32'(cnt_v2), 32'd2);
      chk("cnt_multi", 32'(cnt_multi), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
